// File: rtl/gate_unit_pkg.sv
// Shared definitions for gate_unit: op codes, self-test state encoding and the
// reference truth table used by the built-in self-test.
package gate_unit_pkg;

  localparam logic [2:0] OP_NAND = 3'b000;
  localparam logic [2:0] OP_AND  = 3'b001;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_NOR  = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;
  localparam logic [2:0] OP_NOTA = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } st_state_t;

  // Bit {op, a_bit, b_bit} holds the expected single-bit result of that op.
  localparam logic [31:0] TRUTH_TABLE = 32'hC396_1E87;

endpackage

// File: rtl/gate_unit_core.sv
// Purely combinational bitwise gate, shared by the datapath and the self-test.
module gate_unit_core
  import gate_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_NAND: y = ~(a & b);
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NOR:  y = ~(a | b);
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      OP_NOTA: y = ~a;
      OP_PASS: y = a;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/gate_unit.sv
// Registered bitwise gate unit with valid/ready handshakes on both sides.
// Optional built-in self-test (ports st_*) is compiled in with GATE_UNIT_SELFTEST_EN.
module gate_unit
  import gate_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] c,
  output logic             out_valid,
  input  logic             out_ready
`ifdef GATE_UNIT_SELFTEST_EN
  ,
  input  logic             st_start,
  output logic             st_busy,
  output logic             st_done,
  output logic             st_pass
`endif
);

  // Handshake: a beat moves on a rising edge when valid and ready are both 1;
  // valid never depends on ready, ready may depend on the downstream ready.
  logic [WIDTH-1:0] core_a;
  logic [WIDTH-1:0] core_b;
  logic [2:0]       core_op;
  logic [WIDTH-1:0] core_y;
  logic             transfer;
  logic             consume;

  gate_unit_core #(.WIDTH(WIDTH)) u_core (
    .a  (core_a),
    .b  (core_b),
    .op (core_op),
    .y  (core_y)
  );

  assign transfer = in_valid && in_ready;
  assign consume  = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c         <= '0;
      out_valid <= 1'b0;
    end else if (transfer) begin
      c         <= core_y;
      out_valid <= 1'b1;
    end else if (consume) begin
      out_valid <= 1'b0;
    end
  end

`ifdef GATE_UNIT_SELFTEST_EN
  st_state_t  st_state;
  logic [4:0] st_cnt;
  logic       st_flag;
  logic       st_ok;

  // During RUN the core sees the counter bits replicated across the word.
  assign core_a  = (st_state == ST_RUN) ? {WIDTH{st_cnt[1]}} : a;
  assign core_b  = (st_state == ST_RUN) ? {WIDTH{st_cnt[0]}} : b;
  assign core_op = (st_state == ST_RUN) ? st_cnt[4:2] : op;
  assign st_ok   = (core_y == {WIDTH{TRUTH_TABLE[st_cnt]}});
  assign in_ready = (!out_valid || out_ready) && !st_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_state <= ST_IDLE;
      st_cnt   <= '0;
      st_flag  <= 1'b0;
      st_busy  <= 1'b0;
      st_done  <= 1'b0;
      st_pass  <= 1'b0;
    end else begin
      case (st_state)
        ST_IDLE: begin
          st_done <= 1'b0;
          if (st_start && !out_valid && !in_valid) begin
            st_state <= ST_RUN;
            st_cnt   <= '0;
            st_flag  <= 1'b1;
            st_busy  <= 1'b1;
            st_pass  <= 1'b0;
          end
        end
        ST_RUN: begin
          st_flag <= st_flag && st_ok;
          st_cnt  <= st_cnt + 5'd1;
          if (st_cnt == 5'd31) begin
            st_state <= ST_DONE;
            st_done  <= 1'b1;
            st_pass  <= st_flag && st_ok;
          end
        end
        ST_DONE: begin
          st_state <= ST_IDLE;
          st_done  <= 1'b0;
          st_busy  <= 1'b0;
        end
        default: st_state <= ST_IDLE;
      endcase
    end
  end
`else
  assign core_a   = a;
  assign core_b   = b;
  assign core_op  = op;
  assign in_ready = !out_valid || out_ready;
`endif

endmodule

// File: tb/tb_gate_unit.sv
// Self-checking bench for gate_unit (WIDTH=8); self-test checks run when
// GATE_UNIT_SELFTEST_EN is defined.
module tb_gate_unit;

  logic       clk;
  logic       rst;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] op;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] c;
  logic       out_valid;
  logic       out_ready;
`ifdef GATE_UNIT_SELFTEST_EN
  logic       st_start;
  logic       st_busy;
  logic       st_done;
  logic       st_pass;
`endif

  gate_unit #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .op        (op),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .c         (c),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef GATE_UNIT_SELFTEST_EN
    ,
    .st_start  (st_start),
    .st_busy   (st_busy),
    .st_done   (st_done),
    .st_pass   (st_pass)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  logic       strict = 1'b0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  function automatic logic [7:0] model(input logic [7:0] ma, input logic [7:0] mb,
                                       input logic [2:0] mop);
    case (mop)
      3'd0: return ~(ma & mb);
      3'd1: return ma & mb;
      3'd2: return ma | mb;
      3'd3: return ~(ma | mb);
      3'd4: return ma ^ mb;
      3'd5: return ~(ma ^ mb);
      3'd6: return ~ma;
      default: return ma;
    endcase
  endfunction

  // ---------------- driver ----------------
  task automatic send(input logic [7:0] va, input logic [7:0] vb, input logic [2:0] vop,
                      input logic [7:0] ve);
    int waited;
    waited = 0;
    a = va;
    b = vb;
    op = vop;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: in_ready stuck at 0, expected 1 at %0t", $time);
    end else begin
      exp_q.push_back(ve);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (strict) check("no_bubble", 64'(out_valid), 64'd1);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 64'(c), 64'hx);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          check("scoreboard_c", 64'(c), 64'(e));
        end
      end
    end
  end

`ifdef GATE_UNIT_SELFTEST_EN
  task automatic run_selftest(input logic want_pass, input logic force_bad);
    st_start = 1'b1;
    @(posedge clk);
    #1;
    st_start = 1'b0;
    if (force_bad) force dut.core_y = 8'h00;
    for (int k = 1; k <= 33; k++) begin
      if (k == 5) st_start = 1'b1;
      @(negedge clk);
      check("st_busy", 64'(st_busy), 64'd1);
      check("st_in_ready", 64'(in_ready), 64'd0);
      check("st_done", 64'(st_done), (k == 33) ? 64'd1 : 64'd0);
      if (k == 1) check("st_pass_cleared", 64'(st_pass), 64'd0);
      if (k == 33) check("st_pass", 64'(st_pass), 64'(want_pass));
      if (k == 6) st_start = 1'b0;
    end
    if (force_bad) release dut.core_y;
    @(negedge clk);
    check("st_busy_end", 64'(st_busy), 64'd0);
    check("st_pass_hold", 64'(st_pass), 64'(want_pass));
    @(posedge clk);
    #1;
  endtask
`endif

  // ---------------- test sequence ----------------
  initial begin
    rst = 1'b1;
    a = '0;
    b = '0;
    op = '0;
    in_valid = 1'b0;
    out_ready = 1'b1;
`ifdef GATE_UNIT_SELFTEST_EN
    st_start = 1'b0;
`endif

    tbl[0] = '{8'hF0, 8'hCC, 3'd0, 8'h3F};
    tbl[1] = '{8'hA5, 8'h0F, 3'd0, 8'hFA};
    tbl[2] = '{8'hA5, 8'h0F, 3'd1, 8'h05};
    tbl[3] = '{8'hA5, 8'h0F, 3'd2, 8'hAF};
    tbl[4] = '{8'hA5, 8'h0F, 3'd3, 8'h50};
    tbl[5] = '{8'hA5, 8'h0F, 3'd4, 8'hAA};
    tbl[6] = '{8'hA5, 8'h0F, 3'd5, 8'h55};
    tbl[7] = '{8'hA5, 8'h0F, 3'd6, 8'h5A};
    tbl[8] = '{8'hA5, 8'h0F, 3'd7, 8'hA5};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_c", 64'(c), 64'd0);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
`ifdef GATE_UNIT_SELFTEST_EN
    check("reset_st_busy", 64'(st_busy), 64'd0);
    check("reset_st_done", 64'(st_done), 64'd0);
    check("reset_st_pass", 64'(st_pass), 64'd0);
`endif
    rst = 1'b0;
    @(posedge clk);
    #1;

    // single transfer, one-cycle latency
    send(tbl[0].a, tbl[0].b, tbl[0].op, tbl[0].exp);
    @(negedge clk);
    check("latency_out_valid", 64'(out_valid), 64'd1);
    check("latency_c", 64'(c), 64'(tbl[0].exp));
    @(posedge clk);
    #1;

    // back-to-back op sweep, no bubbles
    for (int i = 1; i < 9; i++) begin
      send(tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].exp);
      if (i == 1) strict = 1'b1;
    end
    @(posedge clk);
    strict = 1'b0;
    #1;

    // random vectors with random idle gaps
    for (int i = 0; i < 24; i++) begin
      logic [7:0] ra, rb;
      logic [2:0] rop;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rop = 3'($urandom_range(0, 7));
      send(ra, rb, rop, model(ra, rb, rop));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    repeat (2) @(posedge clk);
    #1;

    // backpressure: held result blocks the next operand until consumed
    out_ready = 1'b0;
    send(8'h12, 8'h34, 3'd4, 8'h26);
    a = 8'hFF;
    b = 8'h0F;
    op = 3'd1;
    in_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_c_hold", 64'(c), 64'h26);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", 64'(in_ready), 64'd1);
    exp_q.push_back(8'h0F);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_new_c", 64'(c), 64'h0F);
    check("bp_new_valid", 64'(out_valid), 64'd1);
    @(posedge clk);
    #1;

    // asynchronous reset with a result pending
    out_ready = 1'b0;
    send(8'h3C, 8'h0F, 3'd2, 8'h3F);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_c", 64'(c), 64'd0);
    check("async_rst_valid", 64'(out_valid), 64'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    send(8'h81, 8'h18, 3'd5, 8'h66);
    @(negedge clk);
    check("post_rst_valid", 64'(out_valid), 64'd1);
    check("post_rst_c", 64'(c), 64'h66);
    @(posedge clk);
    #1;

`ifdef GATE_UNIT_SELFTEST_EN
    repeat (2) @(posedge clk);
    #1;
    run_selftest(1'b1, 1'b0);
    run_selftest(1'b0, 1'b1);
    send(8'hC3, 8'h5A, 3'd1, 8'h42);
    @(posedge clk);
    #1;
`endif

    // drain scoreboard
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clk);
    @(negedge clk);
    check("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1);
  end

endmodule
